// File: rtl/head_ptr_table_if.sv
// head_ptr_table_if
// Bundles the bus signals of the bucket head-pointer store: the write side
// (head-pointer updates from the insert/delete engines), the lookup request
// channel from the upstream hash stage, the result channel, and the clear
// control.
//   master : the agent that drives updates, lookups and clear requests and
//            consumes results
//   slave  : head_ptr_table itself
// Signal names keep the _i/_o suffixes as seen from the table so they read
// the same on both sides.
interface head_ptr_table_if #(
  parameter int BUCKET_WIDTH = 8,
  parameter int PTR_WIDTH    = 8,
  parameter int TAG_WIDTH    = 32
);
  // write side (no backpressure)
  logic [BUCKET_WIDTH-1:0] wr_addr_i;
  logic [PTR_WIDTH-1:0]    wr_data_ptr_i;
  logic                    wr_data_ptr_val_i;
  logic                    wr_en_i;
  // lookup request
  logic [BUCKET_WIDTH-1:0] lookup_bucket_i;
  logic [TAG_WIDTH-1:0]    lookup_tag_i;
  logic                    lookup_valid_i;
  logic                    lookup_ready_o;
  // lookup result
  logic [BUCKET_WIDTH-1:0] res_bucket_o;
  logic [TAG_WIDTH-1:0]    res_tag_o;
  logic [PTR_WIDTH-1:0]    res_ptr_o;
  logic                    res_ptr_val_o;
  logic                    res_valid_o;
  logic                    res_ready_i;
  // clear control
  logic                    clear_run_i;
  logic                    clear_done_o;

  modport master (
    output wr_addr_i, wr_data_ptr_i, wr_data_ptr_val_i, wr_en_i,
    output lookup_bucket_i, lookup_tag_i, lookup_valid_i,
    input  lookup_ready_o,
    input  res_bucket_o, res_tag_o, res_ptr_o, res_ptr_val_o, res_valid_o,
    output res_ready_i,
    output clear_run_i,
    input  clear_done_o
  );

  modport slave (
    input  wr_addr_i, wr_data_ptr_i, wr_data_ptr_val_i, wr_en_i,
    input  lookup_bucket_i, lookup_tag_i, lookup_valid_i,
    output lookup_ready_o,
    output res_bucket_o, res_tag_o, res_ptr_o, res_ptr_val_o, res_valid_o,
    input  res_ready_i,
    input  clear_run_i,
    output clear_done_o
  );
endinterface

// File: rtl/head_ptr_table.sv
// head_ptr_table
// Bucket head-pointer store for the hash table. Holds one {ptr, ptr_val}
// entry per bucket, accepts head updates from the insert/delete engines,
// answers hashed lookups with the current chain head, and sweeps the whole
// table to zero on request.
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   bus      head_ptr_table_if.slave: write side (wr_*), lookup request
//            (lookup_*), result (res_*), clear control (clear_run_i,
//            clear_done_o)
module head_ptr_table #(
  parameter int BUCKET_WIDTH = 8,
  parameter int PTR_WIDTH    = 8,
  parameter int TAG_WIDTH    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  head_ptr_table_if.slave   bus
);
  localparam int DEPTH       = 2 ** BUCKET_WIDTH;
  localparam int ENTRY_WIDTH = PTR_WIDTH + 1;
  localparam int FIFO_WIDTH  = BUCKET_WIDTH + TAG_WIDTH + ENTRY_WIDTH;

  typedef enum logic {IDLE, CLEAR} clear_state_e;

  clear_state_e            state_q, state_d;
  logic [BUCKET_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                    clear_done;

  logic                    mem_we;
  logic [BUCKET_WIDTH-1:0] mem_waddr;
  logic [ENTRY_WIDTH-1:0]  mem_wdata;

  logic [ENTRY_WIDTH-1:0]  mem [DEPTH];
  logic [ENTRY_WIDTH-1:0]  rd_raw_q, rd_out_q;

  logic                    accept;
  logic                    s1_valid_q, s2_valid_q;
  logic [BUCKET_WIDTH-1:0] s1_bucket_q, s2_bucket_q;
  logic [TAG_WIDTH-1:0]    s1_tag_q, s2_tag_q;
  logic                    s1_fwd_hit_q, s2_fwd_hit_q;
  logic [ENTRY_WIDTH-1:0]  s1_fwd_data_q, s2_fwd_data_q;
  logic [ENTRY_WIDTH-1:0]  push_entry;

  logic [FIFO_WIDTH-1:0]   fifo_mem [4];
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              count_q;
  logic [2:0]              occupancy;
  logic                    push, pop;

  // Clear FSM state and sweep address.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  // Clear FSM next state. A new clear_run_i restarts the sweep at address 0,
  // even from the middle of a sweep.
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    clear_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_run_i) begin
          state_d      = CLEAR;
          clear_addr_d = '0;
        end
      end
      CLEAR: begin
        clear_done = (clear_addr_q == '1);
        if (bus.clear_run_i) begin
          clear_addr_d = '0;
        end else if (clear_addr_q == '1) begin
          state_d = IDLE;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The single RAM write port is owned by the sweeper while clearing;
  // external updates are ignored then. Forwarding looks at this muxed port
  // so in-flight lookups also see the clear writes.
  always_comb begin
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clear_addr_q;
      mem_wdata = '0;
    end else begin
      mem_we    = bus.wr_en_i;
      mem_waddr = bus.wr_addr_i;
      mem_wdata = {bus.wr_data_ptr_i, bus.wr_data_ptr_val_i};
    end
  end

  // RAM with a registered output: read in the accept cycle, data visible two
  // cycles later. A read colliding with a write returns the old entry; the
  // forwarding path below repairs that.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_raw_q <= mem[bus.lookup_bucket_i];
    rd_out_q <= rd_raw_q;
  end

  // Credit: in-flight lookups plus buffered results never exceed the FIFO
  // depth. A clear request in the same cycle also blocks acceptance.
  assign occupancy          = count_q + {2'b00, s1_valid_q} + {2'b00, s2_valid_q};
  assign bus.lookup_ready_o = rst_n_i && (state_q == IDLE) && !bus.clear_run_i &&
                              (occupancy < 3'd4);
  assign accept             = bus.lookup_valid_i && bus.lookup_ready_o;

  // Pipeline valid bits; these are what a reset drops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Pipeline payload. Each stage remembers the newest write to its bucket;
  // a later matching write replaces an earlier one.
  always_ff @(posedge clk_i) begin
    s1_bucket_q   <= bus.lookup_bucket_i;
    s1_tag_q      <= bus.lookup_tag_i;
    s1_fwd_hit_q  <= mem_we && (mem_waddr == bus.lookup_bucket_i);
    s1_fwd_data_q <= mem_wdata;
    s2_bucket_q   <= s1_bucket_q;
    s2_tag_q      <= s1_tag_q;
    if (mem_we && (mem_waddr == s1_bucket_q)) begin
      s2_fwd_hit_q  <= 1'b1;
      s2_fwd_data_q <= mem_wdata;
    end else begin
      s2_fwd_hit_q  <= s1_fwd_hit_q;
      s2_fwd_data_q <= s1_fwd_data_q;
    end
  end

  // Entry pushed into the FIFO: a write in the push cycle itself still
  // counts, otherwise the latest forwarded write, otherwise the RAM data.
  always_comb begin
    if (mem_we && (mem_waddr == s2_bucket_q)) begin
      push_entry = mem_wdata;
    end else if (s2_fwd_hit_q) begin
      push_entry = s2_fwd_data_q;
    end else begin
      push_entry = rd_out_q;
    end
  end

  assign push = s2_valid_q;
  assign pop  = bus.res_valid_o && bus.res_ready_i;

  // Output FIFO pointers and fill count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {s2_bucket_q, s2_tag_q, push_entry};
    end
  end

  assign {bus.res_bucket_o, bus.res_tag_o, bus.res_ptr_o, bus.res_ptr_val_o} = fifo_mem[rd_ptr_q];
  assign bus.res_valid_o  = (count_q != 3'd0);
  assign bus.clear_done_o = clear_done;

endmodule

// File: tb/tb_head_ptr_table.sv
// tb_head_ptr_table
// Self-checking bench for head_ptr_table. A reference model keeps the table
// contents as a plain array, applies each cycle's write (or clear write),
// and resolves every accepted lookup two cycles after acceptance into an
// expected result queue. A separate monitor pops that queue whenever the
// DUT hands over a result. Directed scenarios are followed by random traffic.
module tb_head_ptr_table;
  localparam int BW = 8;
  localparam int PW = 8;
  localparam int TW = 32;
  localparam int N  = 2 ** BW;

  typedef struct {
    logic [BW-1:0] bucket;
    logic [TW-1:0] tag;
    logic [PW-1:0] ptr;
    logic          ptr_val;
    int            acc;
    bit            exact;
  } lookup_t;

  logic clk = 1'b0;
  logic rst_n;

  head_ptr_table_if #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .TAG_WIDTH(TW)) bus ();

  head_ptr_table #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .TAG_WIDTH(TW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  lookup_t       pend_q[$];
  lookup_t       sb_q[$];
  lookup_t       mdl_e;
  lookup_t       mon_e;
  logic [PW:0]   model_mem [N];
  bit            clr_active;
  int            clr_idx;
  int            cyc;
  int            checks;
  int            failures;
  bit            mark_exact;
  bit            head_seen;
  int            head_cyc;
  bit            exp_ready;
  bit            exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One cycle of stimulus, driven just after the active edge.
  task automatic apply_stimulus(input bit lv, input logic [BW-1:0] lb, input logic [TW-1:0] lt,
                                input bit we, input logic [BW-1:0] wa, input logic [PW-1:0] wp,
                                input bit wv, input bit rr, input bit cr);
    @(posedge clk);
    #1;
    bus.lookup_valid_i    = lv;
    bus.lookup_bucket_i   = lb;
    bus.lookup_tag_i      = lt;
    bus.wr_en_i           = we;
    bus.wr_addr_i         = wa;
    bus.wr_data_ptr_i     = wp;
    bus.wr_data_ptr_val_i = wv;
    bus.res_ready_i       = rr;
    bus.clear_run_i       = cr;
  endtask

  task automatic idle(input bit rr);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, rr, 1'b0);
  endtask

  // Lands after the model and monitor have handled the current cycle.
  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic do_lookup(input logic [BW-1:0] b, input logic [TW-1:0] t,
                           input bit exact, input bit rr);
    bit got = 1'b0;
    mark_exact = exact;
    for (int i = 0; i < 50 && !got; i++) begin
      apply_stimulus(1'b1, b, t, 1'b0, '0, '0, 1'b0, rr, 1'b0);
      sample();
      got = bus.lookup_ready_o;
    end
    mark_exact = 1'b0;
    if (!got) check_output("lookup_accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      idle(1'b1);
      sample();
      done = (pend_q.size() == 0) && (sb_q.size() == 0) && !bus.res_valid_o;
    end
    if (!done) check_output("drain_timeout", pend_q.size() + sb_q.size(), 0);
  endtask

  task automatic wait_clear();
    bit done = 1'b0;
    for (int i = 0; i < 2 * N && !done; i++) begin
      idle(1'b1);
      sample();
      done = !clr_active;
    end
    if (!done) check_output("clear_timeout", 0, 1);
  endtask

  // Reference model: table contents, clear sweep, credit and lookup results.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      sb_q.delete();
      clr_active = 1'b0;
      clr_idx    = 0;
      check_output("lookup_ready_in_reset", bus.lookup_ready_o, 0);
      check_output("clear_done_in_reset", bus.clear_done_o, 0);
    end else begin
      if (clr_active) model_mem[clr_idx] = '0;
      else if (bus.wr_en_i) model_mem[bus.wr_addr_i] = {bus.wr_data_ptr_i, bus.wr_data_ptr_val_i};
      while (pend_q.size() > 0 && pend_q[0].acc + 2 <= cyc) begin
        mdl_e = pend_q.pop_front();
        {mdl_e.ptr, mdl_e.ptr_val} = model_mem[mdl_e.bucket];
        sb_q.push_back(mdl_e);
      end
      exp_ready = !clr_active && !bus.clear_run_i && (pend_q.size() + sb_q.size() < 4);
      check_output("lookup_ready", bus.lookup_ready_o, exp_ready);
      if (bus.lookup_valid_i && bus.lookup_ready_o) begin
        mdl_e.bucket  = bus.lookup_bucket_i;
        mdl_e.tag     = bus.lookup_tag_i;
        mdl_e.ptr     = '0;
        mdl_e.ptr_val = 1'b0;
        mdl_e.acc     = cyc;
        mdl_e.exact   = mark_exact;
        pend_q.push_back(mdl_e);
      end
      exp_done = clr_active && (clr_idx == N - 1);
      if (exp_done || bus.clear_done_o) check_output("clear_done", bus.clear_done_o, exp_done);
      if (bus.clear_run_i) begin
        clr_active = 1'b1;
        clr_idx    = 0;
      end else if (clr_active) begin
        if (clr_idx == N - 1) clr_active = 1'b0;
        else clr_idx++;
      end
    end
  end

  // Monitor: compares each consumed result against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      head_seen = 1'b0;
    end else if (bus.res_valid_o) begin
      if (!head_seen) begin
        head_seen = 1'b1;
        head_cyc  = cyc;
      end
      if (bus.res_ready_i) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_result", {bus.res_bucket_o, bus.res_tag_o}, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("result",
                       {bus.res_bucket_o, bus.res_tag_o, bus.res_ptr_o, bus.res_ptr_val_o},
                       {mon_e.bucket, mon_e.tag, mon_e.ptr, mon_e.ptr_val});
          if (mon_e.exact) check_output("result_latency", head_cyc - mon_e.acc, 3);
        end
        head_seen = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_cnt;
    int used;
    bit we;
    bit cr;
    logic [BW-1:0] wa;
    logic [BW-1:0] lb;
    for (int i = 0; i < N; i++) model_mem[i] = '0;
    rst_n                 = 1'b0;
    bus.lookup_valid_i    = 1'b0;
    bus.lookup_bucket_i   = '0;
    bus.lookup_tag_i      = '0;
    bus.wr_en_i           = 1'b0;
    bus.wr_addr_i         = '0;
    bus.wr_data_ptr_i     = '0;
    bus.wr_data_ptr_val_i = 1'b0;
    bus.res_ready_i       = 1'b1;
    bus.clear_run_i       = 1'b0;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check_output("res_valid_in_reset", bus.res_valid_o, 0);
    rst_n = 1'b1;

    // Initial sweep, then every probed bucket reads back empty.
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    wait_clear();
    do_lookup(8'h00, 32'h1111_0000, 1'b0, 1'b1);
    do_lookup(8'h7F, 32'h1111_007F, 1'b0, 1'b1);
    do_lookup(8'hFF, 32'h1111_00FF, 1'b0, 1'b1);
    wait_drain();

    // Update then lookup, with exact three-cycle latency.
    apply_stimulus(1'b0, '0, '0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
    do_lookup(8'h12, 32'hDEAD_BEEF, 1'b1, 1'b1);
    wait_drain();

    // Write two cycles after accept is forwarded; three cycles after is not.
    do_lookup(8'h05, 32'h0505_0002, 1'b0, 1'b1);
    idle(1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 8'h05, 8'h99, 1'b1, 1'b1, 1'b0);
    wait_drain();
    do_lookup(8'h05, 32'h0505_0003, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 8'h05, 8'h55, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Backpressure: only four lookups fit while results are not consumed.
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, BW'(i * 3), TW'(32'hA000_0000 + i), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      sample();
      if (bus.lookup_ready_o) acc_cnt++;
    end
    check_output("bp_accepted", acc_cnt, 4);
    check_output("bp_ready_low", bus.lookup_ready_o, 0);
    wait_drain();

    // Streaming throughput with results consumed every cycle.
    acc_cnt = 0;
    used    = 0;
    while (acc_cnt < 8 && used < 20) begin
      apply_stimulus(1'b1, BW'(used + 40), TW'(32'hB000_0000 + used), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      sample();
      used++;
      if (bus.lookup_ready_o) acc_cnt++;
    end
    check_output("stream_cycles", used, 8);
    wait_drain();

    // Reset with buffered results and a sweep in progress.
    for (int i = 0; i < 3; i++) do_lookup(BW'(i + 1), TW'(32'hC000_0000 + i), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b0);
    check_output("res_valid_before_reset", bus.res_valid_o, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("res_valid_async_reset", bus.res_valid_o, 0);
    check_output("clear_done_async_reset", bus.clear_done_o, 0);
    check_output("lookup_ready_async_reset", bus.lookup_ready_o, 0);
    idle(1'b1);
    idle(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < N + 40; i++) idle(1'b1);
    check_output("ready_after_reset", bus.lookup_ready_o, 1);

    // Random traffic with sweeps (including a restart) mixed in.
    for (int i = 0; i < 2500; i++) begin
      cr = (i == 600) || (i == 700) || (i == 1800);
      we = !clr_active && ($urandom_range(0, 9) < 4);
      wa = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(0, N - 1)) : BW'($urandom_range(0, 15));
      lb = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(0, N - 1)) : BW'($urandom_range(0, 15));
      apply_stimulus($urandom_range(0, 9) < 6, lb, TW'($urandom), we, wa,
                     PW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) < 7, cr);
    end
    wait_clear();
    wait_drain();
    check_output("scoreboard_empty", pend_q.size() + sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
